// File: rtl/rv_pkg.sv
// Shared RISC-V front-end constants used by the fetch stage and its
// neighbours.
package rv_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {instruction, pc} pairs between memory and decode.
// Clear takes priority over push and pop in the same cycle.
import rv_pkg::*;

module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    localparam logic [CW-1:0] DEPTH_CNT = DEPTH[CW-1:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s, do_pop_s;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        do_pop_s  = pop && (count_q != {CW{1'b0}});
        do_push_s = push && ((count_q != DEPTH_CNT) || do_pop_s);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (clear) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Status and head view.
    always_comb begin
        head_data = mem_q[rd_ptr_q];
        count     = count_q;
        empty     = (count_q == {CW{1'b0}});
        full      = (count_q == DEPTH_CNT);
    end

endmodule

// File: rtl/fetch_stage_chk.sv
// Run-time invariants of the fetch stage: the request gate must keep the
// prefetch FIFO from overflowing, and discards never exceed outstanding.
module fetch_stage_chk #(
    parameter int CW = 2
) (
    input logic          clk,
    input logic          rst,
    input logic          fifo_push,
    input logic          fifo_pop,
    input logic          fifo_clear,
    input logic          fifo_full,
    input logic [CW-1:0] inflight,
    input logic [CW-1:0] drop
);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(fifo_push && fifo_full && !fifo_pop && !fifo_clear))
        else $error("fetch_stage: prefetch FIFO overflow");

    a_drop_bounded: assert property (@(posedge clk) disable iff (!rst)
        drop <= inflight)
        else $error("fetch_stage: drop count exceeds outstanding requests");

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order memory requests,
// buffers responses with their PCs and hands them to decode.
import rv_pkg::*;

module fetch_stage #(
    parameter int              XLEN     = rv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(rv_pkg::RESET_PC),
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int            CW        = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_OCC = DEPTH[CW:0];
    localparam logic [XLEN-1:0] STEP    = XLEN'(PC_STEP);

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   exp_pc_q, exp_pc_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     drop_q, drop_d;

    logic [CW-1:0]     fifo_count_s;
    logic              fifo_empty_s, fifo_full_s;
    logic [2*XLEN-1:0] fifo_head_s;
    logic [2*XLEN-1:0] fifo_wdata_s;
    logic [CW:0]       occupancy_s;
    logic [XLEN-1:0]   target_s;
    logic              req_valid_s, fire_s, push_s, pop_s, if_valid_s;

    // Handshake decisions for this cycle.
    always_comb begin
        occupancy_s  = {1'b0, inflight_q} + {1'b0, fifo_count_s};
        req_valid_s  = rst && !redirect_valid && (occupancy_s < DEPTH_OCC);
        fire_s       = req_valid_s && imem_req_ready;
        if_valid_s   = !fifo_empty_s && !redirect_valid;
        pop_s        = if_valid_s && id_ready;
        push_s       = imem_rsp_valid && (drop_q == {CW{1'b0}}) && !redirect_valid;
        target_s     = {redirect_pc[XLEN-1:2], 2'b00};
        fifo_wdata_s = {imem_rsp_data, exp_pc_q};
    end

    // PC and outstanding-response bookkeeping.
    always_comb begin
        inflight_d = inflight_q + CW'(fire_s) - CW'(imem_rsp_valid);
        if (redirect_valid) begin
            fetch_pc_d = target_s;
            exp_pc_d   = target_s;
            // inflight already includes responses earmarked for dropping,
            // so everything still outstanding after this cycle is stale.
            drop_d     = inflight_q - CW'(imem_rsp_valid);
        end else begin
            fetch_pc_d = fire_s ? (fetch_pc_q + STEP) : fetch_pc_q;
            exp_pc_d   = push_s ? (exp_pc_q + STEP) : exp_pc_q;
            if (imem_rsp_valid && (drop_q != {CW{1'b0}})) begin
                drop_d = drop_q - CW'(1'b1);
            end else begin
                drop_d = drop_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            exp_pc_q   <= RESET_PC;
            inflight_q <= {CW{1'b0}};
            drop_q     <= {CW{1'b0}};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            exp_pc_q   <= exp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (fifo_wdata_s),
        .pop       (pop_s),
        .clear     (redirect_valid),
        .head_data (fifo_head_s),
        .count     (fifo_count_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s)
    );

    // Port view; the decode payload reads as zero whenever the FIFO is empty.
    always_comb begin
        imem_req_valid = req_valid_s;
        imem_req_addr  = fetch_pc_q;
        if_valid       = if_valid_s;
        if (fifo_empty_s) begin
            if_instr = {XLEN{1'b0}};
            if_pc    = {XLEN{1'b0}};
        end else begin
            if_instr = fifo_head_s[2*XLEN-1:XLEN];
            if_pc    = fifo_head_s[XLEN-1:0];
        end
    end

    fetch_stage_chk #(
        .CW (CW)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .fifo_push  (push_s),
        .fifo_pop   (pop_s),
        .fifo_clear (redirect_valid),
        .fifo_full  (fifo_full_s),
        .inflight   (inflight_q),
        .drop       (drop_q)
    );

endmodule
